// File: rtl/rng_pwl_evaluate_pkg.sv
// rng_pwl_evaluate_pkg: float field layout, ROM geometry and shared arithmetic helpers
package rng_pwl_evaluate_pkg;
    localparam int BX = 32;
    localparam int BY = 16;
    localparam int K = 4;
    localparam int MANT_BW = 24;
    localparam int EXP_BW = BX - 2 - MANT_BW;
    localparam int G_OCT = 16;
    localparam int D_OCT = 16;
    localparam int AW = $clog2((G_OCT + D_OCT) * (2 ** K));
    localparam int SW = AW - K;
    localparam int SYMM = BX - 1;
    localparam int PART = BX - 2;
    localparam int EXP_MSB = BX - 3;
    localparam int EXP_LSB = MANT_BW;
    localparam int MANT_MSB = MANT_BW - 1;

    typedef struct packed {
        logic          v;
        logic          symm;
        logic [BY-1:0] x;
    } stage_t;

    // Octaves past the table end reuse the last section of their half.
    function automatic logic [AW-1:0] pwl_addr(input logic [BX-1:0] f);
        logic [EXP_BW-1:0] e;
        logic [SW-1:0] sec;
        e = f[EXP_MSB:EXP_LSB];
        sec = f[PART] ? SW'(G_OCT) + (e > EXP_BW'(D_OCT - 1) ? SW'(D_OCT - 1) : SW'(e))
                      : (e > EXP_BW'(G_OCT - 1) ? SW'(G_OCT - 1) : SW'(e));
        return {sec, f[MANT_MSB -: K]};
    endfunction

    function automatic logic [BY:0] pwl_prod(input logic [BY-1:0] c1, input logic [BY-1:0] x);
        logic signed [2*BY:0] p;
        p = $signed({{(BY + 1){c1[BY-1]}}, c1}) * $signed({{(BY + 1){1'b0}}, x});
        return (BY + 1)'(p >>> BY);
    endfunction
endpackage

// File: rtl/rng_sample_fifo.sv
// rng_sample_fifo: synchronous FIFO with occupancy count; head reads zero while empty
module rng_sample_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [CW-1:0]    count_o,
    output logic [WIDTH-1:0] head_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop_i && count_q != '0;
    assign count_o = count_q;
    assign head_o = count_q != '0 ? mem_q[rd_q] : '0;

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= nxt(wr_q);
            if (do_pop) rd_q <= nxt(rd_q);
            count_q <= count_q + CW'(push_i) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/rng_pwl_evaluate.sv
// rng_pwl_evaluate: ROM-addressed piecewise-linear evaluation y = c0 + c1*x with symmetry sign,
// credit flow control into an output FIFO so the pipeline never stalls internally
module rng_pwl_evaluate
    import rng_pwl_evaluate_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [BX-1:0] in_float_i,
    output logic          lut_en_o,
    output logic [AW-1:0] lut_addr_o,
    input  logic [BY-1:0] lut_c0_i,
    input  logic [BY-1:0] lut_c1_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [BY:0]   out_sample_o,
    output logic [15:0]   sat_count_o
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    stage_t p1_q, p1b_q;
    logic [AW-1:0] addr_q;
    logic ready_en_q;
    logic p2_v_q, p2_symm_q;
    logic [BY-1:0] p2_c0_q;
    logic [BY:0] p2_prod_q;
    logic [15:0] sat_q;
    logic [CW-1:0] fifo_count;
    logic [CW:0] used;
    logic accept, clamp_lo, clamp_hi;
    logic signed [BY+1:0] sum;
    logic [BY-1:0] mag;
    logic [BY:0] res_d;

    // Every sample in the pipeline already owns a FIFO slot, so a push can never find it full.
    assign used = (CW + 1)'(fifo_count) + (CW + 1)'(p1_q.v) + (CW + 1)'(p1b_q.v) + (CW + 1)'(p2_v_q);
    assign in_ready_o = ready_en_q && used < (CW + 1)'(FIFO_DEPTH);
    assign accept = in_valid_i && in_ready_o;
    assign lut_en_o = p1_q.v;
    assign lut_addr_o = addr_q;
    assign out_valid_o = fifo_count != '0;
    assign sat_count_o = sat_q;

    always_comb begin
        sum = $signed({2'b00, p2_c0_q}) + $signed({p2_prod_q[BY], p2_prod_q});
        clamp_lo = sum[BY+1];
        clamp_hi = !sum[BY+1] && sum[BY];
        mag = clamp_lo ? '0 : clamp_hi ? '1 : sum[BY-1:0];
        res_d = p2_symm_q ? -{1'b0, mag} : {1'b0, mag};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en_q <= 1'b0;
            p1_q <= '0;
            p1b_q <= '0;
            addr_q <= '0;
            p2_v_q <= 1'b0;
            p2_symm_q <= 1'b0;
            p2_c0_q <= '0;
            p2_prod_q <= '0;
            sat_q <= '0;
        end else begin
            ready_en_q <= 1'b1;
            p1_q.v <= accept;
            if (accept) begin
                p1_q.symm <= in_float_i[SYMM];
                p1_q.x <= in_float_i[MANT_MSB-K -: BY];
                addr_q <= pwl_addr(in_float_i);
            end
            p1b_q <= p1_q;
            p2_v_q <= p1b_q.v;
            p2_symm_q <= p1b_q.symm;
            p2_c0_q <= lut_c0_i;
            p2_prod_q <= pwl_prod(lut_c1_i, p1b_q.x);
            if (p2_v_q && (clamp_lo || clamp_hi) && sat_q != 16'hFFFF) sat_q <= sat_q + 16'd1;
        end
    end

    rng_sample_fifo #(.WIDTH(BY + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push_i(p2_v_q),
        .data_i(res_d),
        .pop_i(out_valid_o && out_ready_i),
        .count_o(fifo_count),
        .head_o(out_sample_o)
    );
endmodule
